// File: rtl/bank_biu_pkg.sv
// Shared types and constants for the bank BIU read-miss engine.
// Optional error reporting is enabled with the BIU_RD_ERR_EN macro.
package bank_biu_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Entry fields are sized for the widest legal configuration (ID up to 16 bits, up to 16 beats).
  localparam int ENTRY_ID_W  = 16;
  localparam int ENTRY_CNT_W = 5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  typedef struct packed {
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [ENTRY_ID_W-1:0]  id;
    logic [ENTRY_CNT_W-1:0] cnt;
  } entry_st_t;

endpackage

// File: rtl/bank_biu_rd_ctrl_if.sv
// Bus bundle of the read-miss engine: HTU request, AXI3 AR/R channels, ISU line return.
// The biu_isu_rerr_o member exists only when BIU_RD_ERR_EN is defined.
interface bank_biu_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 128,
  parameter int LINE_WIDTH = 256,
  parameter int ID_WIDTH   = 6
);
  import bank_biu_pkg::*;
  localparam int OFF = clog2(LINE_WIDTH/8);

  logic                     htu_biu_arvalid_i;
  logic                     htu_biu_arready_o;
  logic [ADDR_WIDTH-OFF-1:0] htu_biu_araddr_i;
  logic [ID_WIDTH-1:0]      htu_biu_set_way_i;
  logic                     biu_axi3_arvalid_o;
  logic                     biu_axi3_arready_i;
  logic [ID_WIDTH-1:0]      biu_axi3_arid_o;
  logic [ADDR_WIDTH-1:0]    biu_axi3_araddr_o;
  logic [3:0]               biu_axi3_arlen_o;
  logic [2:0]               biu_axi3_arsize_o;
  logic [1:0]               biu_axi3_arburst_o;
  logic                     biu_axi3_rvalid_i;
  logic                     biu_axi3_rready_o;
  logic [ID_WIDTH-1:0]      biu_axi3_rid_i;
  logic [BUS_WIDTH-1:0]     biu_axi3_rdata_i;
  logic [1:0]               biu_axi3_rresp_i;
  logic                     biu_axi3_rlast_i;
  logic                     biu_isu_rvalid_o;
  logic                     biu_isu_rready_i;
  logic [LINE_WIDTH-1:0]    biu_isu_rdata_o;
  logic [ID_WIDTH-1:0]      biu_isu_rid_o;
`ifdef BIU_RD_ERR_EN
  logic                     biu_isu_rerr_o;
`endif

  // master: the read controller itself; slave: HTU/AXI/ISU environment
  modport master (
    input  htu_biu_arvalid_i, htu_biu_araddr_i, htu_biu_set_way_i, biu_axi3_arready_i,
           biu_axi3_rvalid_i, biu_axi3_rid_i, biu_axi3_rdata_i, biu_axi3_rresp_i,
           biu_axi3_rlast_i, biu_isu_rready_i,
`ifdef BIU_RD_ERR_EN
    output biu_isu_rerr_o,
`endif
    output htu_biu_arready_o, biu_axi3_arvalid_o, biu_axi3_arid_o, biu_axi3_araddr_o,
           biu_axi3_arlen_o, biu_axi3_arsize_o, biu_axi3_arburst_o, biu_axi3_rready_o,
           biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o
  );

  modport slave (
    output htu_biu_arvalid_i, htu_biu_araddr_i, htu_biu_set_way_i, biu_axi3_arready_i,
           biu_axi3_rvalid_i, biu_axi3_rid_i, biu_axi3_rdata_i, biu_axi3_rresp_i,
           biu_axi3_rlast_i, biu_isu_rready_i,
`ifdef BIU_RD_ERR_EN
    input  biu_isu_rerr_o,
`endif
    input  htu_biu_arready_o, biu_axi3_arvalid_o, biu_axi3_arid_o, biu_axi3_araddr_o,
           biu_axi3_arlen_o, biu_axi3_arsize_o, biu_axi3_arburst_o, biu_axi3_rready_o,
           biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o
  );

endinterface

// File: rtl/bank_biu_rd_entry.sv
// One outstanding-burst tracking entry: ID match, beat counter, line buffer, flags.
// Error flag tracking exists only when BIU_RD_ERR_EN is defined.
module bank_biu_rd_entry
  import bank_biu_pkg::*;
#(
  parameter int BUS_WIDTH  = 128,
  parameter int LINE_WIDTH = 256,
  parameter int ID_WIDTH   = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_i,
  input  logic [ID_WIDTH-1:0]   alloc_id_i,
  input  logic                  free_i,
  input  logic                  rvalid_i,
  input  logic [ID_WIDTH-1:0]   rid_i,
  input  logic [BUS_WIDTH-1:0]  rdata_i,
`ifdef BIU_RD_ERR_EN
  input  logic [1:0]            rresp_i,
  output logic                  err_o,
`endif
  input  logic                  rlast_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic [LINE_WIDTH-1:0] line_o
);

  localparam int BEATS = LINE_WIDTH/BUS_WIDTH;

  entry_st_t             st_q, st_d;
  logic                  hit, in_range;
  logic [LINE_WIDTH-1:0] line_q;
  logic                  unused_st;

  assign hit      = rvalid_i & st_q.busy & ~st_q.done & (st_q.id[ID_WIDTH-1:0] == rid_i);
  assign in_range = st_q.cnt < ENTRY_CNT_W'(BEATS);
  assign unused_st = ^{st_q.id, st_q.err};

  always_comb begin
    st_d = st_q;
    if (free_i) begin
      st_d.busy = 1'b0;
      st_d.done = 1'b0;
    end
    if (alloc_i) begin
      st_d                    = '0;
      st_d.busy               = 1'b1;
      st_d.id[ID_WIDTH-1:0]   = alloc_id_i;
    end
    if (hit) begin
      // Counter saturates at BEATS so overrun beats never touch the buffer.
      if (in_range) st_d.cnt = st_q.cnt + ENTRY_CNT_W'(1);
      if (rlast_i)  st_d.done = 1'b1;
`ifdef BIU_RD_ERR_EN
      if (!in_range || (rresp_i != AXI_RESP_OKAY) ||
          (rlast_i && (st_q.cnt != ENTRY_CNT_W'(BEATS-1))))
        st_d.err = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) st_q <= '0;
    else         st_q <= st_d;
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < BEATS; k++)
      if (hit && (st_q.cnt == ENTRY_CNT_W'(k)))
        line_q[k*BUS_WIDTH +: BUS_WIDTH] <= rdata_i;
  end

  assign busy_o = st_q.busy;
  assign done_o = st_q.done;
  assign id_o   = st_q.id[ID_WIDTH-1:0];
  assign line_o = line_q;
`ifdef BIU_RD_ERR_EN
  assign err_o  = st_q.err;
`endif

endmodule

// File: rtl/bank_biu_rd_ctrl.sv
// Bank BIU read-miss engine: issues AXI3 INCR line bursts and returns assembled lines to the ISU.
// Define BIU_RD_ERR_EN to add the biu_isu_rerr_o line error flag.
module bank_biu_rd_ctrl
  import bank_biu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 128,
  parameter int LINE_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int MAX_OUTS   = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  bank_biu_rd_ctrl_if.master bus
);

  localparam int BEATS = LINE_WIDTH/BUS_WIDTH;
  localparam int OFF   = clog2(LINE_WIDTH/8);
  localparam int IDX_W = (MAX_OUTS > 1) ? clog2(MAX_OUTS) : 1;

  logic [MAX_OUTS-1:0]   busy, done, alloc, free, gnt;
  logic [ID_WIDTH-1:0]   ent_id   [MAX_OUTS];
  logic [LINE_WIDTH-1:0] ent_line [MAX_OUTS];
  logic                  id_hit, any_free, go, fire, any_done, load;
  logic [IDX_W-1:0]      gnt_idx, rr_q;
  logic [LINE_WIDTH-1:0] sel_line, rdata_q;
  logic [ID_WIDTH-1:0]   sel_id, rid_q;
  logic                  rvalid_q;
  logic [ADDR_WIDTH-1:0] araddr;
`ifdef BIU_RD_ERR_EN
  logic [MAX_OUTS-1:0]   err;
  logic                  sel_err, rerr_q;
`else
  logic                  unused_rresp;
  assign unused_rresp = ^bus.biu_axi3_rresp_i;
`endif

  for (genvar g = 0; g < MAX_OUTS; g++) begin : g_ent
    bank_biu_rd_entry #(
      .BUS_WIDTH (BUS_WIDTH),
      .LINE_WIDTH(LINE_WIDTH),
      .ID_WIDTH  (ID_WIDTH)
    ) u_ent (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .alloc_i   (alloc[g]),
      .alloc_id_i(bus.htu_biu_set_way_i),
      .free_i    (free[g]),
      .rvalid_i  (bus.biu_axi3_rvalid_i),
      .rid_i     (bus.biu_axi3_rid_i),
      .rdata_i   (bus.biu_axi3_rdata_i),
`ifdef BIU_RD_ERR_EN
      .rresp_i   (bus.biu_axi3_rresp_i),
      .err_o     (err[g]),
`endif
      .rlast_i   (bus.biu_axi3_rlast_i),
      .busy_o    (busy[g]),
      .done_o    (done[g]),
      .id_o      (ent_id[g]),
      .line_o    (ent_line[g])
    );
  end

  // Allocator: an ID already in flight stalls the request so R beats stay unambiguous.
  always_comb begin
    id_hit   = 1'b0;
    alloc    = '0;
    any_free = ~&busy;
    for (int i = 0; i < MAX_OUTS; i++)
      if (busy[i] && (ent_id[i] == bus.htu_biu_set_way_i)) id_hit = 1'b1;
    go   = bus.htu_biu_arvalid_i & any_free & ~id_hit;
    fire = go & bus.biu_axi3_arready_i;
    for (int i = MAX_OUTS-1; i >= 0; i--)
      if (!busy[i]) begin
        alloc    = '0;
        alloc[i] = fire;
      end
  end

  // Round-robin over done entries, searching from just after the last grant.
  always_comb begin
    int j;
    j        = 0;
    gnt      = '0;
    gnt_idx  = rr_q;
    any_done = 1'b0;
    sel_line = '0;
    sel_id   = '0;
`ifdef BIU_RD_ERR_EN
    sel_err  = 1'b0;
`endif
    for (int off = 1; off <= MAX_OUTS; off++) begin
      j = (int'(rr_q) + off) % MAX_OUTS;
      if (!any_done && done[j]) begin
        any_done = 1'b1;
        gnt_idx  = IDX_W'(j);
        gnt[j]   = 1'b1;
        sel_line = ent_line[j];
        sel_id   = ent_id[j];
`ifdef BIU_RD_ERR_EN
        sel_err  = err[j];
`endif
      end
    end
  end

  assign load = ~rvalid_q | bus.biu_isu_rready_i;
  assign free = gnt & {MAX_OUTS{load}};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rr_q     <= IDX_W'(MAX_OUTS-1);
`ifdef BIU_RD_ERR_EN
      rerr_q   <= 1'b0;
`endif
    end else if (load) begin
      rvalid_q <= any_done;
      if (any_done) begin
        rdata_q <= sel_line;
        rid_q   <= sel_id;
        rr_q    <= gnt_idx;
`ifdef BIU_RD_ERR_EN
        rerr_q  <= sel_err;
`endif
      end
    end
  end

  assign araddr                 = {bus.htu_biu_araddr_i, {OFF{1'b0}}};
  assign bus.htu_biu_arready_o  = fire;
  assign bus.biu_axi3_arvalid_o = go;
  assign bus.biu_axi3_arid_o    = bus.htu_biu_set_way_i;
  assign bus.biu_axi3_araddr_o  = araddr;
  assign bus.biu_axi3_arlen_o   = 4'(BEATS-1);
  assign bus.biu_axi3_arsize_o  = 3'(clog2(BUS_WIDTH/8));
  assign bus.biu_axi3_arburst_o = AXI_BURST_INCR;
  assign bus.biu_axi3_rready_o  = 1'b1;
  assign bus.biu_isu_rvalid_o   = rvalid_q;
  assign bus.biu_isu_rdata_o    = rdata_q;
  assign bus.biu_isu_rid_o      = rid_q;
`ifdef BIU_RD_ERR_EN
  assign bus.biu_isu_rerr_o     = rerr_q;
`endif

endmodule

// File: tb/tb_bank_biu_rd_ctrl.sv
// Self-checking bench for bank_biu_rd_ctrl (BUS=128, LINE=256, MAX_OUTS=4); honours BIU_RD_ERR_EN.
module tb_bank_biu_rd_ctrl;

  localparam int AW = 32, BW = 128, LW = 256, IW = 6, MO = 4, LAW = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_biu_rd_ctrl_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW), .LINE_WIDTH(LW), .ID_WIDTH(IW)) ifc ();

  bank_biu_rd_ctrl #(
    .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .LINE_WIDTH(LW), .ID_WIDTH(IW), .MAX_OUTS(MO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [LW-1:0] data;
    logic          err;
  } exp_t;

  typedef struct {
    logic [LAW-1:0] la;
    logic [IW-1:0]  id;
    logic [AW-1:0]  exp_araddr;
    logic [BW-1:0]  b0;
    logic [BW-1:0]  b1;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[4];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [BW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: every ISU handoff is compared with the oldest expected line.
  always @(negedge clk) begin
    if (rst_n && ifc.biu_isu_rvalid_o && ifc.biu_isu_rready_i) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: line id %0h delivered, none expected", ifc.biu_isu_rid_o);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_rid", 64'(ifc.biu_isu_rid_o), 64'(mon_e.id));
        n_chk++;
        if (ifc.biu_isu_rdata_o === mon_e.data) n_pass++;
        else $display("FAIL sb_rdata: got %h expected %h", ifc.biu_isu_rdata_o, mon_e.data);
`ifdef BIU_RD_ERR_EN
        chk("sb_rerr", 64'(ifc.biu_isu_rerr_o), 64'(mon_e.err));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [IW-1:0] id, input logic [BW-1:0] d,
                           input logic [1:0] resp, input logic last);
    ifc.biu_axi3_rvalid_i = 1'b1;
    ifc.biu_axi3_rid_i    = id;
    ifc.biu_axi3_rdata_i  = d;
    ifc.biu_axi3_rresp_i  = resp;
    ifc.biu_axi3_rlast_i  = last;
    step();
    ifc.biu_axi3_rvalid_i = 1'b0;
    ifc.biu_axi3_rlast_i  = 1'b0;
    ifc.biu_axi3_rresp_i  = 2'b00;
  endtask

  task automatic issue(input logic [LAW-1:0] la, input logic [IW-1:0] id);
    bit ok;
    ok = 1'b0;
    ifc.htu_biu_arvalid_i = 1'b1;
    ifc.htu_biu_araddr_i  = la;
    ifc.htu_biu_set_way_i = id;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.htu_biu_arready_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("issue_accept", 64'(ok), 64'd1);
    step();
    ifc.htu_biu_arvalid_i = 1'b0;
  endtask

  task automatic send_line(input logic [IW-1:0] id, input logic [1:0] resp0, input logic err);
    logic [BW-1:0] b0, b1;
    b0 = rnd128();
    b1 = rnd128();
    sb.push_back('{id, {b1, b0}, err});
    send_beat(id, b0, resp0, 1'b0);
    send_beat(id, b1, 2'b00, 1'b1);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    step();
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [LW-1:0] line8;
    logic [BW-1:0] a8, b8;
    ifc.htu_biu_arvalid_i  = 1'b0;
    ifc.htu_biu_araddr_i   = '0;
    ifc.htu_biu_set_way_i  = '0;
    ifc.biu_axi3_arready_i = 1'b1;
    ifc.biu_axi3_rvalid_i  = 1'b0;
    ifc.biu_axi3_rid_i     = '0;
    ifc.biu_axi3_rdata_i   = '0;
    ifc.biu_axi3_rresp_i   = 2'b00;
    ifc.biu_axi3_rlast_i   = 1'b0;
    ifc.biu_isu_rready_i   = 1'b1;

    vecs[0] = '{27'h0000092, 6'h05, 32'h0000_1240, 128'hAAAA_0000_1111_2222_3333_4444_5555_6666,
                128'hBBBB_7777_8888_9999_0000_1111_2222_3333};
    vecs[1] = '{27'h7FF_FFFF, 6'h3F, 32'hFFFF_FFE0, rnd128(), rnd128()};
    vecs[2] = '{27'h0000000, 6'h00, 32'h0000_0000, rnd128(), rnd128()};
    vecs[3] = '{27'h2AA_AAAA, 6'h2A, 32'h5555_5540, rnd128(), rnd128()};

    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rvalid",  64'(ifc.biu_isu_rvalid_o), 64'd0);
    chk("rst_rid",     64'(ifc.biu_isu_rid_o), 64'd0);
    chk("rst_rdata",   64'(|ifc.biu_isu_rdata_o), 64'd0);
    chk("rst_arvalid", 64'(ifc.biu_axi3_arvalid_o), 64'd0);
    chk("rst_arready", 64'(ifc.htu_biu_arready_o), 64'd0);
    chk("rst_rready",  64'(ifc.biu_axi3_rready_o), 64'd1);
    step();

    // Table: AR fields, two-beat assembly and rlast-to-rvalid latency.
    for (int v = 0; v < 4; v++) begin
      ifc.htu_biu_arvalid_i = 1'b1;
      ifc.htu_biu_araddr_i  = vecs[v].la;
      ifc.htu_biu_set_way_i = vecs[v].id;
      @(negedge clk);
      chk("ar_valid",  64'(ifc.biu_axi3_arvalid_o), 64'd1);
      chk("ar_ready",  64'(ifc.htu_biu_arready_o), 64'd1);
      chk("ar_addr",   64'(ifc.biu_axi3_araddr_o), 64'(vecs[v].exp_araddr));
      chk("ar_id",     64'(ifc.biu_axi3_arid_o), 64'(vecs[v].id));
      chk("ar_len",    64'(ifc.biu_axi3_arlen_o), 64'd1);
      chk("ar_size",   64'(ifc.biu_axi3_arsize_o), 64'd4);
      chk("ar_burst",  64'(ifc.biu_axi3_arburst_o), 64'd1);
      step();
      ifc.htu_biu_arvalid_i = 1'b0;
      sb.push_back('{vecs[v].id, {vecs[v].b1, vecs[v].b0}, 1'b0});
      send_beat(vecs[v].id, vecs[v].b0, 2'b00, 1'b0);
      send_beat(vecs[v].id, vecs[v].b1, 2'b00, 1'b1);
      @(negedge clk);
      chk("lat_t1_rvalid", 64'(ifc.biu_isu_rvalid_o), 64'd0);
      @(negedge clk);
      chk("lat_t2_rvalid", 64'(ifc.biu_isu_rvalid_o), 64'd1);
      chk("lat_t2_rid",    64'(ifc.biu_isu_rid_o), 64'(vecs[v].id));
      step();
    end
    drain("table_drain");

    // Full: four outstanding, fifth waits until id 2 is handed over.
    for (int i = 1; i <= 4; i++) issue(LAW'(i * 16), IW'(i));
    ifc.htu_biu_arvalid_i = 1'b1;
    ifc.htu_biu_araddr_i  = LAW'(80);
    ifc.htu_biu_set_way_i = 6'd5;
    repeat (3) begin
      @(negedge clk);
      chk("full_arready", 64'(ifc.htu_biu_arready_o), 64'd0);
      chk("full_arvalid", 64'(ifc.biu_axi3_arvalid_o), 64'd0);
    end
    step();
    send_line(6'd2, 2'b00, 1'b0);
    @(negedge clk);
    chk("full_done_arready", 64'(ifc.htu_biu_arready_o), 64'd0);
    @(negedge clk);
    chk("full_out_rid", 64'(ifc.biu_isu_rid_o), 64'd2);
    chk("full_freed_arready", 64'(ifc.htu_biu_arready_o), 64'd1);
    step();
    ifc.htu_biu_arvalid_i = 1'b0;
    send_line(6'd1, 2'b00, 1'b0);
    send_line(6'd3, 2'b00, 1'b0);
    send_line(6'd4, 2'b00, 1'b0);
    send_line(6'd5, 2'b00, 1'b0);
    drain("full_drain");

    // Same ID: second id 7 stalls until the first id 7 line leaves its entry.
    issue(LAW'(7), 6'd7);
    ifc.htu_biu_arvalid_i = 1'b1;
    ifc.htu_biu_araddr_i  = LAW'(8);
    ifc.htu_biu_set_way_i = 6'd7;
    a8 = rnd128();
    b8 = rnd128();
    sb.push_back('{6'd7, {b8, a8}, 1'b0});
    send_beat(6'd7, a8, 2'b00, 1'b0);
    @(negedge clk);
    chk("dup_stall_beat", 64'(ifc.biu_axi3_arvalid_o), 64'd0);
    step();
    send_beat(6'd7, b8, 2'b00, 1'b1);
    @(negedge clk);
    chk("dup_stall_done", 64'(ifc.biu_axi3_arvalid_o), 64'd0);
    @(negedge clk);
    chk("dup_out_rvalid", 64'(ifc.biu_isu_rvalid_o), 64'd1);
    chk("dup_issue", 64'(ifc.biu_axi3_arvalid_o), 64'd1);
    step();
    ifc.htu_biu_arvalid_i = 1'b0;
    send_line(6'd7, 2'b00, 1'b0);
    drain("dup_drain");

    // Interleaved R beats of two IDs.
    issue(LAW'(100), 6'd1);
    issue(LAW'(200), 6'd2);
    begin
      logic [BW-1:0] x0, x1, y0, y1;
      x0 = rnd128(); x1 = rnd128(); y0 = rnd128(); y1 = rnd128();
      sb.push_back('{6'd1, {x1, x0}, 1'b0});
      sb.push_back('{6'd2, {y1, y0}, 1'b0});
      send_beat(6'd1, x0, 2'b00, 1'b0);
      send_beat(6'd2, y0, 2'b00, 1'b0);
      send_beat(6'd1, x1, 2'b00, 1'b1);
      send_beat(6'd2, y1, 2'b00, 1'b1);
    end
    drain("ilv_drain");

    // Backpressure: output held stable, second line one cycle after release.
    issue(LAW'(300), 6'd8);
    issue(LAW'(301), 6'd9);
    ifc.biu_isu_rready_i = 1'b0;
    a8 = rnd128();
    b8 = rnd128();
    line8 = {b8, a8};
    sb.push_back('{6'd8, line8, 1'b0});
    send_beat(6'd8, a8, 2'b00, 1'b0);
    send_beat(6'd8, b8, 2'b00, 1'b1);
    send_line(6'd9, 2'b00, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_rvalid", 64'(ifc.biu_isu_rvalid_o), 64'd1);
      chk("hold_rid",    64'(ifc.biu_isu_rid_o), 64'd8);
      chk("hold_rdata",  64'(ifc.biu_isu_rdata_o === line8), 64'd1);
    end
    step();
    ifc.biu_isu_rready_i = 1'b1;
    @(negedge clk);
    chk("rel_first_rid", 64'(ifc.biu_isu_rid_o), 64'd8);
    @(negedge clk);
    chk("rel_second_rvalid", 64'(ifc.biu_isu_rvalid_o), 64'd1);
    chk("rel_second_rid",    64'(ifc.biu_isu_rid_o), 64'd9);
    drain("bp_drain");

    // Reset mid-burst, stray beat afterwards, then an error-response line.
    issue(LAW'(400), 6'd3);
    send_beat(6'd3, rnd128(), 2'b00, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    send_beat(6'd3, rnd128(), 2'b00, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("stray_rvalid", 64'(ifc.biu_isu_rvalid_o), 64'd0);
    end
    step();
    issue(LAW'(401), 6'd3);
    send_line(6'd3, 2'b10, 1'b1);
    drain("err_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
